// File: rtl/div_requester.sv
// Request queue and start/done initiator for the iterative divider.
// Queues operand pairs, runs one division at a time and returns tagged results.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a queued request; pops it and screens for den == 0
// START | div_start high for exactly this cycle; timeout timer loaded
// ARM   | waiting for div_done to read low (stale done from last op)
// WAIT  | waiting for div_done high; captures quotient/remainder
// RESP  | out_valid high, result held until out_ready
module div_requester #(
    parameter int SIZE    = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_num,
    input  logic [SIZE-1:0] in_den,
    output logic            div_start,
    output logic [SIZE-1:0] div_numerador,
    output logic [SIZE-1:0] div_denominador,
    input  logic [SIZE-1:0] div_cociente,
    input  logic [SIZE-1:0] div_resto,
    input  logic            div_done,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_cociente,
    output logic [SIZE-1:0] out_resto,
    output logic            out_divzero,
    output logic            out_timeout,
    output logic            out_mismatch
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;

    logic [SIZE-1:0] fifo_num [DEPTH];
    logic [SIZE-1:0] fifo_den [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [SIZE-1:0] head_num;
    logic [SIZE-1:0] head_den;
    logic [TW-1:0]   tmr;

    logic [2*SIZE-1:0] check_sum;
    logic              mismatch_c;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state == S_IDLE) && !empty;
    assign head_num = fifo_num[rd_ptr[AW-1:0]];
    assign head_den = fifo_den[rd_ptr[AW-1:0]];

    // Widened so q*d + r cannot wrap and hide a bad result.
    assign check_sum = {{SIZE{1'b0}}, div_cociente} * {{SIZE{1'b0}}, div_denominador}
                     + {{SIZE{1'b0}}, div_resto};
    assign mismatch_c = (check_sum != {{SIZE{1'b0}}, div_numerador}) ||
                        (div_resto >= div_denominador);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_num[wr_ptr[AW-1:0]] <= in_num;
            fifo_den[wr_ptr[AW-1:0]] <= in_den;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            tmr             <= '0;
            div_start       <= 1'b0;
            div_numerador   <= '0;
            div_denominador <= '0;
            out_valid       <= 1'b0;
            out_cociente    <= '0;
            out_resto       <= '0;
            out_divzero     <= 1'b0;
            out_timeout     <= 1'b0;
            out_mismatch    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        div_numerador   <= head_num;
                        div_denominador <= head_den;
                        if (head_den == '0) begin
                            out_cociente <= '1;
                            out_resto    <= head_num;
                            out_divzero  <= 1'b1;
                            out_timeout  <= 1'b0;
                            out_mismatch <= 1'b0;
                            out_valid    <= 1'b1;
                            state        <= S_RESP;
                        end else begin
                            div_start <= 1'b1;
                            state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    div_start <= 1'b0;
                    tmr       <= TW'(TIMEOUT - 1);
                    state     <= S_ARM;
                end
                S_ARM, S_WAIT: begin
                    if (state == S_WAIT && div_done) begin
                        out_cociente <= div_cociente;
                        out_resto    <= div_resto;
                        out_divzero  <= 1'b0;
                        out_timeout  <= 1'b0;
                        out_mismatch <= mismatch_c;
                        out_valid    <= 1'b1;
                        state        <= S_RESP;
                    end else if (tmr == '0) begin
                        out_cociente <= '0;
                        out_resto    <= '0;
                        out_divzero  <= 1'b0;
                        out_timeout  <= 1'b1;
                        out_mismatch <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        tmr <= tmr - 1'b1;
                        if (state == S_ARM && !div_done) state <= S_WAIT;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_requester.sv
// Directed bench for div_requester with a behavioural divider that can stall
// forever or return forced (wrong) results.
module tb_div_requester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_num;
    logic [31:0] in_den;
    logic        div_start;
    logic [31:0] div_numerador;
    logic [31:0] div_denominador;
    logic [31:0] div_cociente;
    logic [31:0] div_resto;
    logic        div_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_cociente;
    logic [31:0] out_resto;
    logic        out_divzero;
    logic        out_timeout;
    logic        out_mismatch;

    int n_checks = 0;
    int n_pass   = 0;

    div_requester #(.SIZE(32), .DEPTH(4), .TIMEOUT(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_num         (in_num),
        .in_den         (in_den),
        .div_start      (div_start),
        .div_numerador  (div_numerador),
        .div_denominador(div_denominador),
        .div_cociente   (div_cociente),
        .div_resto      (div_resto),
        .div_done       (div_done),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_cociente   (out_cociente),
        .out_resto      (out_resto),
        .out_divzero    (out_divzero),
        .out_timeout    (out_timeout),
        .out_mismatch   (out_mismatch)
    );

    always #5 clk = ~clk;

    // Divider model: done three edges after it sees start, held until the next
    // start. mode 0 = correct, 1 = never done, 2 = forced q/r.
    int          mode    = 0;
    logic [31:0] force_q = '0;
    logic [31:0] force_r = '0;
    logic        busy_m  = 1'b0;
    int          cnt_m   = 0;
    int          start_cnt = 0;

    initial begin
        div_done     = 1'b0;
        div_cociente = '0;
        div_resto    = '0;
    end

    always @(posedge clk) begin
        if (div_start) begin
            start_cnt = start_cnt + 1;
            div_done <= 1'b0;
            busy_m   <= 1'b1;
            cnt_m    <= 3;
        end else if (busy_m) begin
            if (cnt_m == 1) begin
                busy_m <= 1'b0;
                if (mode == 2) begin
                    div_cociente <= force_q;
                    div_resto    <= force_r;
                    div_done     <= 1'b1;
                end else if (mode == 0) begin
                    div_cociente <= div_numerador / div_denominador;
                    div_resto    <= div_numerador % div_denominador;
                    div_done     <= 1'b1;
                end
            end else begin
                cnt_m <= cnt_m - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] n, input logic [31:0] d);
        in_num   = n;
        in_den   = d;
        in_valid = 1'b1;
        check("push_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, "_valid"}, out_valid, 1);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, out_valid, 0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                                input logic dz, input logic to, input logic mm);
        check({tag, "_q"},  out_cociente, q);
        check({tag, "_r"},  out_resto, r);
        check({tag, "_dz"}, out_divzero, dz);
        check({tag, "_to"}, out_timeout, to);
        check({tag, "_mm"}, out_mismatch, mm);
    endtask

    logic [31:0] bp_num [8] = '{32'd1000, 32'd77, 32'd255, 32'd12345, 32'd6, 32'd11, 32'd22, 32'd33};
    logic [31:0] bp_den [8] = '{32'd10,   32'd5,  32'd16,  32'd100,   32'd7, 32'd2,  32'd3,  32'd4};
    logic [31:0] bp_q   [5] = '{32'd100,  32'd15, 32'd15,  32'd123,   32'd0};
    logic [31:0] bp_r   [5] = '{32'd0,    32'd2,  32'd15,  32'd45,    32'd6};

    initial begin
        int cyc;
        int s0;
        int acc;
        logic saw_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_num    = '0;
        in_den    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_div_start", div_start, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_div_num", div_numerador, 0);
        check("rst_div_den", div_denominador, 0);
        check_result("rst", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 100 / 7 with latency: pop, start, arm, 3-cycle divider, capture
        s0 = start_cnt;
        push(32'd100, 32'd7);
        wait_valid("d100_7", cyc);
        check("d100_7_latency", cyc, 6);
        check_result("d100_7", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        check("d100_7_starts", start_cnt - s0, 1);
        consume("d100_7");

        // divide by zero answered straight from IDLE
        s0 = start_cnt;
        push(32'h10, 32'd0);
        wait_valid("dz", cyc);
        check("dz_latency", cyc, 1);
        check_result("dz", 32'hFFFF_FFFF, 32'h10, 1'b1, 1'b0, 1'b0);
        check("dz_starts", start_cnt - s0, 0);
        consume("dz");

        // backpressure: 4 queued + 1 in service
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            in_num   = bp_num[i];
            in_den   = bp_den[i];
            in_valid = 1'b1;
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, 5);
        check("bp_in_ready_low", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            wait_valid("bp", cyc);
            check_result("bp", bp_q[i], bp_r[i], 1'b0, 1'b0, 1'b0);
            consume("bp");
        end
        check("bp_in_ready_back", in_ready, 1);

        // divider never finishes: abort 64 cycles after ARM entry (edge 2)
        mode = 1;
        push(32'd40, 32'd8);
        wait_valid("to", cyc);
        check("to_latency", cyc, 66);
        check_result("to", 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        consume("to");
        mode = 0;
        push(32'd40, 32'd8);
        wait_valid("after_to", cyc);
        check_result("after_to", 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
        consume("after_to");

        // wrong arithmetic: 7*7+2 != 50
        mode = 2; force_q = 32'd7; force_r = 32'd2;
        push(32'd50, 32'd7);
        wait_valid("mm_sum", cyc);
        check_result("mm_sum", 32'd7, 32'd2, 1'b0, 1'b0, 1'b1);
        consume("mm_sum");

        // consistent sum but remainder not below divisor: 6*7+7 == 49
        force_q = 32'd6; force_r = 32'd7;
        push(32'd49, 32'd7);
        wait_valid("mm_rem", cyc);
        check_result("mm_rem", 32'd6, 32'd7, 1'b0, 1'b0, 1'b1);
        consume("mm_rem");

        // reset while stuck in WAIT with two requests queued
        mode = 1;
        push(32'd81, 32'd9);
        push(32'd64, 32'd8);
        push(32'd25, 32'd5);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_div_start", div_start, 0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        saw_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("mrst_no_result", saw_valid, 0);
        check("mrst_in_ready_after", in_ready, 1);
        push(32'd9, 32'd3);
        wait_valid("post_rst", cyc);
        check_result("post_rst", 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);
        consume("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
